// File: rtl/vga_pixel_fifo_out.sv
// vga_pixel_fifo_out: FIFO-buffered RGB444 output stage locked to start-of-frame,
// blanking and resyncing on underflow or frame misalignment.
module vga_pixel_fifo_out #(
    parameter int FIFO_DEPTH = 16,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [11:0]      s_color,
    input  logic             s_sof,
    input  logic             visible,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [9:0]       column,
    input  logic [9:0]       row,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             underflow,
    output logic             misalign,
    output logic [ERR_W-1:0] err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_SOF, ARMED, STREAM} state_t;

    state_t        state_q, state_d;
    logic [12:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [12:0]   head;
    logic [11:0]   color_d;
    logic          push, pop, empty, fstart, head_sof, uf_d, ma_d;

    assign s_ready  = (cnt_q != (AW+1)'(FIFO_DEPTH)) && !reset;
    assign push     = s_valid && s_ready;
    assign empty    = cnt_q == '0;
    assign head     = mem_q[rd_q];
    assign head_sof = !empty && head[12];
    assign fstart   = visible && column == '0 && row == '0;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        color_d = '0;
        uf_d    = 1'b0;
        ma_d    = 1'b0;
        case (state_q)
            WAIT_SOF: if (!empty) begin
                if (head[12]) state_d = ARMED;
                else pop = 1'b1;
            end
            ARMED: if (fstart && head_sof) begin
                pop     = 1'b1;
                color_d = head[11:0];
                state_d = STREAM;
            end
            STREAM: if (visible) begin
                if (empty) begin
                    uf_d    = 1'b1;
                    state_d = WAIT_SOF;
                end else if (fstart == head[12]) begin
                    pop     = 1'b1;
                    color_d = head[11:0];
                end else begin
                    // sof at fstart is missing (late) or arrived mid-frame (early)
                    ma_d    = 1'b1;
                    state_d = fstart ? WAIT_SOF : ARMED;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {s_sof, s_color};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= WAIT_SOF;
            wr_q               <= '0;
            rd_q               <= '0;
            cnt_q              <= '0;
            {red, green, blue} <= '0;
            hsync_o            <= 1'b1;
            vsync_o            <= 1'b1;
            underflow          <= 1'b0;
            misalign           <= 1'b0;
            err_count          <= '0;
        end else begin
            state_q            <= state_d;
            wr_q               <= wr_q + AW'(push);
            rd_q               <= rd_q + AW'(pop);
            cnt_q              <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            {red, green, blue} <= color_d;
            hsync_o            <= hsync_i;
            vsync_o            <= vsync_i;
            underflow          <= uf_d;
            misalign           <= ma_d;
            if ((uf_d || ma_d) && err_count != '1) err_count <= err_count + ERR_W'(1);
        end
    end
endmodule

// File: tb/tb_vga_pixel_fifo_out.sv
// tb_vga_pixel_fifo_out: directed and random stimulus checked each cycle against a
// queue-based frame-locking reference model.
module tb_vga_pixel_fifo_out;
    localparam int DEPTH = 16;
    localparam int M_WAIT = 0, M_ARM = 1, M_STR = 2;

    logic clk = 1'b0, reset = 1'b1;
    logic s_valid = 1'b0, s_ready, s_sof = 1'b0;
    logic [11:0] s_color = '0;
    logic visible = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1;
    logic [9:0] column = '0, row = '0;
    logic [3:0] red, green, blue;
    logic hsync_o, vsync_o, underflow, misalign;
    logic [7:0] err_count;

    int tests = 0, fails = 0;
    logic [12:0] q[$];
    int mode = M_WAIT;
    logic [11:0] e_col = '0;
    logic e_hs = 1'b1, e_vs = 1'b1, e_uf = 1'b0, e_ma = 1'b0;
    int e_err = 0;

    vga_pixel_fifo_out #(.FIFO_DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_color(s_color),
        .s_sof(s_sof), .visible(visible), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .column(column), .row(row), .red(red), .green(green), .blue(blue),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .underflow(underflow), .misalign(misalign),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from the model, advance, compare every output.
    task automatic cyc(input logic v, input logic [9:0] col, input logic [9:0] rw,
                       input logic sv, input logic [11:0] c, input logic s);
        logic fs, acc, emp, pop;
        logic [12:0] h;
        visible = v; column = col; row = rw;
        s_valid = sv; s_color = c; s_sof = s;
        hsync_i = 1'($urandom); vsync_i = 1'($urandom);
        #1;
        chk("s_ready", s_ready, !reset && q.size() < DEPTH);
        acc = sv && !reset && q.size() < DEPTH;
        fs  = v && col == 0 && rw == 0;
        emp = q.size() == 0;
        h   = emp ? 13'h0 : q[0];
        pop = 1'b0; e_col = '0; e_uf = 1'b0; e_ma = 1'b0;
        if (mode == M_WAIT) begin
            if (!emp && !h[12]) pop = 1'b1;
            else if (!emp) mode = M_ARM;
        end else if (mode == M_ARM) begin
            if (fs && !emp && h[12]) begin pop = 1'b1; e_col = h[11:0]; mode = M_STR; end
        end else if (v) begin
            if (emp) begin e_uf = 1'b1; mode = M_WAIT; end
            else if (fs && !h[12]) begin e_ma = 1'b1; mode = M_WAIT; end
            else if (!fs && h[12]) begin e_ma = 1'b1; mode = M_ARM; end
            else begin pop = 1'b1; e_col = h[11:0]; end
        end
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({s, c});
        if ((e_uf || e_ma) && e_err < 255) e_err++;
        e_hs = hsync_i; e_vs = vsync_i;
        if (reset) begin
            q.delete(); mode = M_WAIT; e_col = '0; e_uf = 1'b0; e_ma = 1'b0;
            e_err = 0; e_hs = 1'b1; e_vs = 1'b1;
        end
        @(posedge clk); #1;
        chk("color", {red, green, blue}, e_col);
        chk("hsync_o", hsync_o, e_hs);
        chk("vsync_o", vsync_o, e_vs);
        chk("underflow", underflow, e_uf);
        chk("misalign", misalign, e_ma);
        chk("err_count", err_count, e_err);
    endtask

    initial begin
        @(posedge clk); #1;
        cyc(0, 10, 5, 1, 12'hfff, 1);
        cyc(0, 10, 5, 0, 0, 0);
        reset = 1'b0;
        // frame start displays four pushed pixels in order
        cyc(0, 10, 5, 1, 12'h111, 1);
        cyc(0, 11, 5, 1, 12'h222, 0);
        cyc(0, 12, 5, 1, 12'h333, 0);
        cyc(0, 13, 5, 1, 12'h444, 0);
        cyc(1, 0, 0, 0, 0, 0);  chk("t1_px0", {red, green, blue}, 12'h111);
        cyc(1, 1, 0, 0, 0, 0);  chk("t1_px1", {red, green, blue}, 12'h222);
        cyc(1, 2, 0, 0, 0, 0);  chk("t1_px2", {red, green, blue}, 12'h333);
        cyc(1, 3, 0, 0, 0, 0);  chk("t1_px3", {red, green, blue}, 12'h444);
        cyc(1, 4, 0, 0, 0, 0);  chk("t1_uf", underflow, 1); chk("t1_err", err_count, 1);
        // fill to full with output stalled, then stream while pushing
        for (int i = 0; i < 17; i++) cyc(0, 20, 7, 1, 12'(i + 1), i == 0);
        chk("t2_full", s_ready, 0);
        cyc(1, 0, 0, 1, 12'($urandom), 0);
        for (int i = 1; i < 20; i++) cyc(1, 10'(i), 0, 1, 12'($urandom), 0);
        // drain to underflow, discard non-sof data, resume only at frame start
        for (int i = 20; i < 40; i++) cyc(1, 10'(i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 50, 0, 1, 12'hbad, 0);
        cyc(0, 50, 0, 1, 12'h5a5, 1);
        for (int i = 0; i < 3; i++) cyc(1, 10'(60 + i), 3, 0, 0, 0);
        chk("t3_blank", {red, green, blue}, 0);
        cyc(1, 0, 0, 0, 0, 0);  chk("t3_resume", {red, green, blue}, 12'h5a5);
        // early sof mid-line
        cyc(0, 90, 0, 1, 12'h0a1, 0);
        cyc(0, 90, 0, 1, 12'h0a2, 0);
        cyc(0, 90, 0, 1, 12'h7c3, 1);
        cyc(0, 90, 0, 1, 12'h0a4, 0);
        cyc(1, 1, 0, 0, 0, 0);  chk("t4_a", {red, green, blue}, 12'h0a1);
        cyc(1, 2, 0, 0, 0, 0);  chk("t4_b", {red, green, blue}, 12'h0a2);
        cyc(1, 3, 0, 0, 0, 0);  chk("t4_ma", misalign, 1);
        chk("t4_err", err_count, 3);
        cyc(1, 4, 0, 0, 0, 0);  chk("t4_hold", {red, green, blue}, 0);
        cyc(1, 0, 0, 0, 0, 0);  chk("t4_sof", {red, green, blue}, 12'h7c3);
        cyc(1, 1, 0, 0, 0, 0);  chk("t4_next", {red, green, blue}, 12'h0a4);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic fz;
            fz = $urandom_range(0, 19) == 0;
            cyc($urandom_range(0, 3) != 0, fz ? 10'd0 : 10'($urandom_range(1, 639)),
                fz ? 10'd0 : 10'($urandom_range(0, 479)), 1'($urandom),
                12'($urandom), $urandom_range(0, 7) == 0);
        end
        // saturate the error counter with repeated underflows
        reset = 1'b1; cyc(0, 5, 5, 0, 0, 0); reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 5, 5, 1, 12'($urandom), 1);
            cyc(0, 5, 5, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 0);
            cyc(1, 5, 0, 0, 0, 0);
        end
        chk("t5_sat", err_count, 255);
        cyc(0, 5, 5, 1, 12'h123, 1);
        cyc(1, 0, 0, 1, 12'h456, 0);
        reset = 1'b1;
        cyc(1, 1, 0, 1, 12'h789, 0);
        chk("t5_rst_col", {red, green, blue}, 0);
        chk("t5_rst_sync", {hsync_o, vsync_o}, 2'b11);
        chk("t5_rst_err", err_count, 0);
        chk("t5_rst_rdy", s_ready, 0);
        reset = 1'b0;
        cyc(1, 2, 0, 0, 0, 0);
        chk("t5_rdy_after", s_ready, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
